// File: rtl/ysyx_22050133_divider.sv
// Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and W-suffixed ops.
// Quotient and remainder come out together; divide-by-zero and signed overflow follow RISC-V rules.
module ysyx_22050133_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   ITER_FULL = CW'(XLEN);
  localparam logic [CW-1:0]   ITER_WORD = CW'(32);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_C     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_C     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + ONE_C) : v;
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   dvd_r, dvs_r, prem_r, quo_r;
  logic [XLEN-1:0]   quotient_r, remainder_r;
  logic              qneg_r, rneg_r, w_r;

  logic              accept_s, a_neg_s, b_neg_s, div_zero_s, a_min_s, ovf_s, special_s;
  logic [XLEN-1:0]   a_eff_s, b_eff_s, a_abs_s, b_abs_s, dvd_load_s, dvs_load_s;
  logic [XLEN-1:0]   spec_q_s, spec_r_s;
  logic [XLEN:0]     shift_s, diff_s;
  logic              qbit_s;
  logic [XLEN-1:0]   prem_nx_s, quo_nx_s, q_fix_s, r_fix_s, q_res_s, r_res_s;

  assign accept_s   = (state_r == IDLE) & div_valid & ~flush;

  // Word mode works on sign-extended [31:0] so sign tests and magnitudes share one path.
  assign a_eff_s    = divw ? sext32(dividend[31:0]) : dividend;
  assign b_eff_s    = divw ? sext32(divisor[31:0])  : divisor;
  assign a_neg_s    = div_signed & a_eff_s[XLEN-1];
  assign b_neg_s    = div_signed & b_eff_s[XLEN-1];
  assign a_abs_s    = neg_if(a_eff_s, a_neg_s);
  assign b_abs_s    = neg_if(b_eff_s, b_neg_s);
  assign dvd_load_s = divw ? {a_abs_s[31:0], {(XLEN-32){1'b0}}} : a_abs_s;
  assign dvs_load_s = divw ? {{(XLEN-32){1'b0}}, b_abs_s[31:0]} : b_abs_s;

  assign div_zero_s = (b_eff_s == ZERO_C);
  assign a_min_s    = divw ? (dividend[31:0] == 32'h8000_0000) : (dividend == MIN_C);
  assign ovf_s      = div_signed & a_min_s & (b_eff_s == ONES_C);
  assign special_s  = div_zero_s | ovf_s;
  assign spec_q_s   = div_zero_s ? ONES_C : a_eff_s;
  assign spec_r_s   = div_zero_s ? a_eff_s : ZERO_C;

  // One restoring step: the dividend MSB feeds the partial remainder, borrow decides the bit.
  assign shift_s    = {prem_r, dvd_r[XLEN-1]};
  assign diff_s     = shift_s - {1'b0, dvs_r};
  assign qbit_s     = ~diff_s[XLEN];
  assign prem_nx_s  = qbit_s ? diff_s[XLEN-1:0] : shift_s[XLEN-1:0];
  assign quo_nx_s   = {quo_r[XLEN-2:0], qbit_s};
  assign q_fix_s    = neg_if(quo_nx_s, qneg_r);
  assign r_fix_s    = neg_if(prem_nx_s, rneg_r);
  assign q_res_s    = w_r ? sext32(q_fix_s[31:0]) : q_fix_s;
  assign r_res_s    = w_r ? sext32(r_fix_s[31:0]) : r_fix_s;

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = special_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= CNT_ZERO;
      dvd_r       <= ZERO_C;
      dvs_r       <= ZERO_C;
      prem_r      <= ZERO_C;
      quo_r       <= ZERO_C;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      w_r         <= 1'b0;
      quotient_r  <= ZERO_C;
      remainder_r <= ZERO_C;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            w_r    <= divw;
            qneg_r <= a_neg_s ^ b_neg_s;
            rneg_r <= a_neg_s;
            dvd_r  <= dvd_load_s;
            dvs_r  <= dvs_load_s;
            prem_r <= ZERO_C;
            quo_r  <= ZERO_C;
            if (special_s) begin
              cnt_r       <= CNT_ZERO;
              quotient_r  <= spec_q_s;
              remainder_r <= spec_r_s;
            end else begin
              cnt_r <= divw ? ITER_WORD : ITER_FULL;
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            dvd_r  <= {dvd_r[XLEN-2:0], 1'b0};
            prem_r <= prem_nx_s;
            quo_r  <= quo_nx_s;
            cnt_r  <= cnt_r - CNT_LAST;
            if (cnt_r == CNT_LAST) begin
              quotient_r  <= q_res_s;
              remainder_r <= r_res_s;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign div_ready = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_ysyx_22050133_divider.sv
// Scoreboard bench for ysyx_22050133_divider: a driver queues expected results from an
// arithmetic reference model, a negedge monitor pops and compares on every out_valid.
module tb_ysyx_22050133_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  ysyx_22050133_divider #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .divw(divw),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;
  logic [63:0] last_q = 64'd0;
  logic [63:0] last_r = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain RISC-V division semantics with the two special cases spelled out.
  task automatic ref_model(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic s, output logic [63:0] q, output logic [63:0] r,
                           output int lat);
    logic [31:0] a32, b32, q32, r32;
    int          ai, bi;
    longint      al, bl;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      ai  = a32;
      bi  = b32;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; lat = 1;
      end else if (s) begin
        q32 = 32'(ai / bi); r32 = 32'(ai % bi); lat = 33;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32; lat = 33;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      al = a;
      bl = b;
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0; lat = 1;
      end else if (s) begin
        q = 64'(al / bl); r = 64'(al % bl); lat = 65;
      end else begin
        q = a / b; r = a % b; lat = 65;
      end
    end
  endtask

  // Monitor: compare each result against the oldest expectation; busy means not ready.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL spurious_out_valid: got 1 expected 0 (q=%h r=%h)", quotient, remainder);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
          last_q = e.q;
          last_r = e.r;
        end
      end else if (sb.size() > 0) begin
        chk("ready_low_busy", {63'd0, div_ready}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                       input logic s, input bit track);
    exp_t e;
    int   n;
    ref_model(a, b, w, s, e.q, e.r, e.lat);
    @(negedge clk);
    n = 0;
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) begin
      checks++;
      errs++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end else begin
      dividend   = a;
      divisor    = b;
      divw       = w;
      div_signed = s;
      div_valid  = 1'b1;
      e.cyc      = cyc;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      if (track) sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    logic        w, s;
    int          mode;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", {63'd0, div_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);

    issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);                       wait_idle();
    issue(-64'sd7, 64'd2, 1'b0, 1'b1, 1'b1);                       wait_idle();
    issue(64'd7, -64'sd2, 1'b0, 1'b1, 1'b1);                       wait_idle();
    issue(64'h1234, 64'd0, 1'b0, 1'b0, 1'b1);                      wait_idle();
    issue(64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1); wait_idle();
    issue(64'hAAAA_AAAA_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b1);       wait_idle();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(64'h1234_5678_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b1); wait_idle();

    // Flush ten cycles in: no result, ready next cycle, outputs held.
    issue(64'd999, 64'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {63'd0, div_ready}, 64'd1);
    chk("flush_quotient_held", quotient, last_q);
    chk("flush_remainder_held", remainder, last_r);
    repeat (80) @(negedge clk);
    chk("flush_quotient_held_late", quotient, last_q);
    issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);                       wait_idle();

    // Flush while idle blocks acceptance.
    @(negedge clk);
    flush = 1'b1;
    div_valid = 1'b1;
    dividend = 64'd50;
    divisor = 64'd5;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_blocks", {63'd0, div_ready}, 64'd1);

    // Asynchronous reset mid-operation clears outputs with no clock edge.
    issue(64'hFFFF_0000_1234_5678, 64'd12345, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_quotient", quotient, 64'd0);
    chk("async_rst_remainder", remainder, 64'd0);
    sb.delete();
    last_q = 64'd0;
    last_r = 64'd0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized back-to-back traffic, biased toward the special cases.
    for (int i = 0; i < 48; i++) begin
      w    = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = w ? {$urandom, 32'd0} : 64'd0;
        1: begin
          s = 1'b1;
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: b = {$urandom, 32'(($urandom_range(1, 15)))} & (w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_000F);
        3: b = -64'($urandom_range(1, 9));
        4: a = 64'($urandom_range(0, 1000));
        default: b = b;
      endcase
      if (b == 64'd0 && mode == 2) b = 64'd3;
      issue(a, b, w, s, 1'b1);
    end
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
